seven_seg_controller: RTL

Display controller that drives the four-digit seven-segment display. Accepts a 16-bit hex value from the datapath via a load strobe and owns the scan prescaler, the digit sequencer and the hex-to-segment decode. Loads are double-buffered so a value only changes at a frame boundary, which prevents tearing. All outputs are registered and go straight to the board pins.

---
 rtl/seven_seg_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_controller
//  Description : Four-digit multiplexed seven-segment display controller.
//                Prescaled digit scan, double-buffered 16-bit hex value with
//                per-digit decimal points, registered active-low pin outputs.
//                Optional macro BLANK_LEADING_ZEROS_EN blanks leading zero
//                digits (3..1) while keeping the slot timing unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_controller #(
   parameter int DIV_COUNT = 100000,
   parameter int CNT_WIDTH = 17
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   output logic [3:0]  anode,
   output logic [6:0]  segment,
   output logic        dp,
   output logic        frame_done
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DIV_COUNT - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] prescale;
   logic [1:0]           digit_idx;
   logic                 tick;
   logic                 boundary;

   logic [15:0]          active_value;
   logic [3:0]           active_dp;
   logic [15:0]          pending_value;
   logic [3:0]           pending_dp;
   logic                 pending_valid;

   logic [3:0]           cur_nibble;
   logic [6:0]           cur_segment;
   logic                 cur_blank;

   // A frozen (disabled) scan never produces a tick, so no boundary either.
   assign tick     = enable && (prescale == CNT_LAST);
   assign boundary = tick && (digit_idx == 2'd3);

   // Prescaler and digit index: advance only while scanning.
   always_ff @(posedge clock) begin
      if (reset) begin
         prescale  <= '0;
         digit_idx <= 2'd0;
      end else if (enable) begin
         if (tick) begin
            prescale  <= '0;
            digit_idx <= digit_idx + 2'd1;
         end else begin
            prescale  <= prescale + CNT_ONE;
         end
      end
   end

   // Double buffer: loads park in pending and move to active at a frame
   // boundary; a load landing on the boundary itself goes straight through.
   always_ff @(posedge clock) begin
      if (reset) begin
         active_value  <= 16'h0000;
         active_dp     <= 4'h0;
         pending_value <= 16'h0000;
         pending_dp    <= 4'h0;
         pending_valid <= 1'b0;
      end else if (load && boundary) begin
         active_value  <= value;
         active_dp     <= dp_in;
         pending_valid <= 1'b0;
      end else begin
         if (boundary && pending_valid) begin
            active_value  <= pending_value;
            active_dp     <= pending_dp;
            pending_valid <= 1'b0;
         end
         if (load) begin
            pending_value <= value;
            pending_dp    <= dp_in;
            pending_valid <= 1'b1;
         end
      end
   end

   // Select the nibble for the digit currently being scanned.
   always_comb begin
      cur_nibble = active_value[3:0];
      case (digit_idx)
         2'd0:    cur_nibble = active_value[3:0];
         2'd1:    cur_nibble = active_value[7:4];
         2'd2:    cur_nibble = active_value[11:8];
         default: cur_nibble = active_value[15:12];
      endcase
   end

   // Hex to active-low {g,f,e,d,c,b,a}.
   always_comb begin
      cur_segment = 7'b1111111;
      case (cur_nibble)
         4'h0: cur_segment = 7'b1000000;
         4'h1: cur_segment = 7'b1111001;
         4'h2: cur_segment = 7'b0100100;
         4'h3: cur_segment = 7'b0110000;
         4'h4: cur_segment = 7'b0011001;
         4'h5: cur_segment = 7'b0010010;
         4'h6: cur_segment = 7'b0000010;
         4'h7: cur_segment = 7'b1111000;
         4'h8: cur_segment = 7'b0000000;
         4'h9: cur_segment = 7'b0010000;
         4'hA: cur_segment = 7'b0001000;
         4'hB: cur_segment = 7'b0000011;
         4'hC: cur_segment = 7'b1000110;
         4'hD: cur_segment = 7'b0100001;
         4'hE: cur_segment = 7'b0000110;
         default: cur_segment = 7'b0001110;
      endcase
   end

`ifdef BLANK_LEADING_ZEROS_EN
   // A digit is a leading zero when it and every higher nibble are zero and
   // its decimal point is off; digit 0 always shows.
   always_comb begin
      cur_blank = 1'b0;
      case (digit_idx)
         2'd3:    cur_blank = (active_value[15:12] == 4'h0)  && !active_dp[3];
         2'd2:    cur_blank = (active_value[15:8]  == 8'h00) && !active_dp[2];
         2'd1:    cur_blank = (active_value[15:4]  == 12'h000) && !active_dp[1];
         default: cur_blank = 1'b0;
      endcase
   end
`else
   assign cur_blank = 1'b0;
`endif

   // Registered pin drivers; blanked slots keep their time so brightness
   // stays uniform across digits.
   always_ff @(posedge clock) begin
      if (reset) begin
         anode      <= 4'b1111;
         segment    <= 7'b1111111;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else if (!enable) begin
         anode      <= 4'b1111;
         segment    <= 7'b1111111;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         if (cur_blank) begin
            anode   <= 4'b1111;
            segment <= 7'b1111111;
            dp      <= 1'b1;
         end else begin
            anode   <= ~(4'b0001 << digit_idx);
            segment <= cur_segment;
            dp      <= ~active_dp[digit_idx];
         end
      end
   end

endmodule
`default_nettype wire
